cpu_bus_unit: RTL and testbench
===============================

# cpu_bus_unit

Parametrised bus interface unit for the pipelined MIPS core. It merges the core's instruction-fetch port and data-memory port onto one shared single-port memory bus with a request/grant/response handshake. The unit asserts a pipeline stall while any access is outstanding, so the core no longer needs single-cycle separate memories. It sits between the `cpu` top level and the memory/bus fabric.

## Interface
- `DATA_W`, 16, data and instruction word width
- `ADDR_W`, 16, address width (word addresses)
- `clk  input  1  clock; all state updates on rising edge`
- `reset  input  1  asynchronous, active-low reset`
- `if_req  input  1  core requests instruction at if_addr`
- `if_addr  input  ADDR_W  fetch address; may change while pending (branch redirect)`
- `if_rdata  output  DATA_W  fetched instruction`
- `if_valid  output  1  if_rdata valid this cycle`
- `mem_rd`, `mem_wr  input  1  data read/write request; never both set`
- `mem_addr  input  ADDR_W  data address`
- `mem_wdata  input  DATA_W  store data`
- `mem_rdata  output  DATA_W  load data`
- `mem_done  output  1  data access completes this cycle`
- `stall  output  1  freeze pipeline`
- `bus_req  output  1  bus request`
- `bus_we  output  1  1 = write`
- `bus_addr  output  ADDR_W  bus address`
- `bus_wdata  output  DATA_W  bus write data`
- `bus_gnt  input  1  bus accepts request this cycle`
- `bus_rvalid  input  1  response (read data or write ack)`
- `bus_rdata  input  DATA_W  read data`

## Operation
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT. One outstanding bus transaction maximum.
- IDLE: a data request takes priority over `if_req` and moves the FSM to D_REQ; `if_req` alone moves it to I_REQ. The address, write enable and write data are captured into registers on that transition.
- X_REQ: `bus_req`=1 with the captured fields. On `bus_gnt`, go to X_WAIT. The request stays held until granted.
- X_WAIT: on `bus_rvalid`, complete, then go back to IDLE.
- Data completion: `mem_done`=1 and `mem_rdata`=`bus_rdata` for that cycle. Writes also need `bus_rvalid` as an acknowledgement.
- Fetch completion: `if_valid`=1 and `if_rdata`=`bus_rdata`, but only if `if_addr` equals the captured address.
  - If the address differs (redirect), the response is discarded.
  - The FSM then goes back to IDLE and reissues the fetch for the new address.
- `stall` = (`mem_rd`|`mem_wr`) & ~`mem_done`, OR `if_req` & ~`if_valid`.
- The core holds the data request fields stable while `stall`=1.
- `bus_rvalid` in IDLE or X_REQ is ignored.

## Timing
- Reset values: FSM=IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `if_valid`=0, `mem_done`=0, `stall`=0, `mem_rdata`=0, `if_rdata`=0.
- Minimum latency for an uncached access is 2 cycles:
  - Request seen in cycle 0.
  - `bus_req` asserted in cycle 1 with `bus_gnt` in cycle 1.
  - `bus_rvalid` in cycle 2; `mem_done`/`if_valid` are combinational from it in cycle 2.
- A data request and a fetch arriving together are serialised. Data goes first, and the fetch issues in the cycle after `mem_done` at the earliest.
- `bus_req` is registered and never glitches. It drops in the cycle after `bus_gnt`.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and `bus_req` drops asynchronously. A late `bus_rvalid` from the abandoned transaction is ignored.

## Configuration
- Macro `CPU_BUS_FETCH_BUF_EN`.
- Defined: a one-entry fetch buffer holds {valid, tag, word} for the last completed fetch.
  - If `if_req` hits the buffer in IDLE, `if_valid`=1 in the same cycle, with no bus access and no stall.
  - A data write with `mem_addr`==tag clears valid on completion.
  - Reset clears valid.
- Undefined: every fetch goes to the bus. The behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`:
  - FSM state encoding (3-bit localparams).
  - Default `DATA_W`/`ADDR_W`.
- One natural sub-module, `cpu_fetch_buf`: tag/valid register, hit compare, write invalidate. It is instantiated only under `CPU_BUS_FETCH_BUF_EN`.

## Test plan
- Fetch of 0x0010 with `bus_gnt` in cycle 1 and `bus_rvalid`+0xABCD in cycle 2 → `if_valid`, `if_rdata`=0xABCD in cycle 2; `stall`=1 in cycles 0–1.
- `mem_wr` to 0x0200 and `if_req` 0x0011 together → bus sees the write to 0x0200 first, `mem_done`, then a read of 0x0011; `stall` stays high throughout.
- `bus_gnt` held low for 5 cycles during a load from 0x0300 → `bus_req` and `bus_addr`=0x0300 stay stable; `mem_rdata` is correct when `bus_rvalid` arrives.
- Fetch 0x0020 pending, `if_addr` changes to 0x0040 before `bus_rvalid` → response discarded, no `if_valid`, refetch of 0x0040 completes.
- `reset` driven low in D_WAIT, late `bus_rvalid` after release → all outputs at reset values, no `mem_done`.
- With `CPU_BUS_FETCH_BUF_EN`: refetch of 0x0010 → hit, no `bus_req`. Store to 0x0010, then fetch 0x0010 → miss and bus read.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core bus interface unit.
// Holds the default bus widths and the bus FSM state encoding.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_D_REQ  = 3'd1;
    localparam logic [2:0] ST_D_WAIT = 3'd2;
    localparam logic [2:0] ST_I_REQ  = 3'd3;
    localparam logic [2:0] ST_I_WAIT = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        D_REQ  = ST_D_REQ,
        D_WAIT = ST_D_WAIT,
        I_REQ  = ST_I_REQ,
        I_WAIT = ST_I_WAIT
    } bus_state_t;

endpackage

// File: rtl/cpu_fetch_buf.sv
// One-entry fetch buffer: remembers the last completed instruction fetch
// so a repeated fetch of the same address is answered without a bus access.
// A completed data write to the buffered address invalidates the entry.
// Only instantiated when CPU_BUS_FETCH_BUF_EN is defined.
module cpu_fetch_buf
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv_en,
    input  logic [ADDR_W-1:0] inv_addr,
    output logic              hit,
    output logic [DATA_W-1:0] word
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;

    // Fill on a completed fetch, drop the entry when a store overwrites it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (inv_en && (inv_addr == tag)) begin
            valid <= 1'b0;
        end
    end

    assign hit  = valid && (tag == lookup_addr);
    assign word = data;

endmodule

// File: rtl/cpu_bus_unit.sv
// Bus interface unit for the pipelined MIPS core.
// Merges the instruction-fetch and data-memory ports onto one single-port
// request/grant/response bus, with at most one transaction outstanding,
// and stalls the pipeline while an access is pending.
// Optional feature macro: CPU_BUS_FETCH_BUF_EN (one-entry fetch buffer).
// Reset is asynchronous and active-low on the port named reset.
module cpu_bus_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    bus_state_t        state;
    bus_state_t        next_state;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [DATA_W-1:0] cap_wdata;
    logic              data_req;
    logic              start_d;
    logic              start_i;
    logic              fetch_done;
    logic              buf_serve;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_word;

    assign data_req = mem_rd | mem_wr;

`ifdef CPU_BUS_FETCH_BUF_EN
    cpu_fetch_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fetch_buf (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (if_addr),
        .fill_en     (fetch_done),
        .fill_addr   (cap_addr),
        .fill_data   (bus_rdata),
        .inv_en      (mem_done && cap_we),
        .inv_addr    (cap_addr),
        .hit         (buf_hit),
        .word        (buf_word)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    // Data wins over fetch in IDLE; a buffered fetch never needs the bus.
    assign start_d = (state == IDLE) && data_req;
    assign start_i = (state == IDLE) && !data_req && if_req && !buf_hit;

    // State register plus registered bus request and captured bus fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
        end else begin
            state   <= next_state;
            bus_req <= (next_state == D_REQ) || (next_state == I_REQ);
            if (start_d) begin
                cap_addr  <= mem_addr;
                cap_we    <= mem_wr;
                cap_wdata <= mem_wdata;
            end else if (start_i) begin
                cap_addr  <= if_addr;
                cap_we    <= 1'b0;
                cap_wdata <= '0;
            end
        end
    end

    // Next-state logic: request until granted, wait for the response, return.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_d) begin
                    next_state = D_REQ;
                end else if (start_i) begin
                    next_state = I_REQ;
                end
            end
            D_REQ:   if (bus_gnt)    next_state = D_WAIT;
            D_WAIT:  if (bus_rvalid) next_state = IDLE;
            I_REQ:   if (bus_gnt)    next_state = I_WAIT;
            I_WAIT:  if (bus_rvalid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Completion strobes and returned data; a redirected fetch drops its response.
    always_comb begin
        mem_done   = (state == D_WAIT) && bus_rvalid;
        fetch_done = (state == I_WAIT) && bus_rvalid && (if_addr == cap_addr);
        buf_serve  = (state == IDLE) && if_req && buf_hit;
        mem_rdata  = '0;
        if_rdata   = '0;
        if (mem_done) begin
            mem_rdata = bus_rdata;
        end
        if (fetch_done) begin
            if_rdata = bus_rdata;
        end else if (buf_serve) begin
            if_rdata = buf_word;
        end
        if_valid = fetch_done | buf_serve;
        stall    = (data_req & ~mem_done) | (if_req & ~if_valid);
    end

    assign bus_we    = cap_we;
    assign bus_addr  = cap_addr;
    assign bus_wdata = cap_wdata;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Directed testbench for cpu_bus_unit.
// Inputs are driven on the falling clock edge and outputs are sampled 1ns
// later, well away from the rising edge where the design updates.
// The fetch-buffer section runs only when CPU_BUS_FETCH_BUF_EN is defined.
module tb_cpu_bus_unit;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [15:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    cpu_bus_unit #(
        .DATA_W (16),
        .ADDR_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .stall      (stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected test end");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait for the next falling edge, then drive a complete input vector.
    task automatic applyStimulus(input logic ireq, input logic [15:0] iaddr,
                                 input logic rd, input logic wr,
                                 input logic [15:0] maddr, input logic [15:0] wdata,
                                 input logic gnt, input logic rvalid,
                                 input logic [15:0] rdata);
        @(negedge clk);
        if_req     = ireq;
        if_addr    = iaddr;
        mem_rd     = rd;
        mem_wr     = wr;
        mem_addr   = maddr;
        mem_wdata  = wdata;
        bus_gnt    = gnt;
        bus_rvalid = rvalid;
        bus_rdata  = rdata;
        #1;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0; mem_addr = 0;
        mem_wdata = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_bus_req",   bus_req,   0);
        checkOutput("rst_bus_we",    bus_we,    0);
        checkOutput("rst_bus_addr",  bus_addr,  0);
        checkOutput("rst_bus_wdata", bus_wdata, 0);
        checkOutput("rst_if_valid",  if_valid,  0);
        checkOutput("rst_mem_done",  mem_done,  0);
        checkOutput("rst_stall",     stall,     0);
        checkOutput("rst_mem_rdata", mem_rdata, 0);
        checkOutput("rst_if_rdata",  if_rdata,  0);
        @(negedge clk);
        reset = 1'b1;

        // Fetch 0x0010, minimum latency
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f1_c0_stall",   stall,   1);
        checkOutput("f1_c0_bus_req", bus_req, 0);
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("f1_c1_bus_req",  bus_req,  1);
        checkOutput("f1_c1_bus_addr", bus_addr, 16'h0010);
        checkOutput("f1_c1_bus_we",   bus_we,   0);
        checkOutput("f1_c1_stall",    stall,    1);
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0, 1, 16'hABCD);
        checkOutput("f1_c2_if_valid", if_valid, 1);
        checkOutput("f1_c2_if_rdata", if_rdata, 16'hABCD);
        checkOutput("f1_c2_stall",    stall,    0);
        checkOutput("f1_c2_bus_req",  bus_req,  0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f1_c3_if_valid", if_valid, 0);
        checkOutput("f1_c3_bus_req",  bus_req,  0);

        // Simultaneous store to 0x0200 and fetch of 0x0011: data first
        applyStimulus(1, 16'h0011, 0, 1, 16'h0200, 16'h1234, 0, 0, 0);
        checkOutput("wf_c0_stall", stall, 1);
        applyStimulus(1, 16'h0011, 0, 1, 16'h0200, 16'h1234, 1, 0, 0);
        checkOutput("wf_c1_bus_req",   bus_req,   1);
        checkOutput("wf_c1_bus_we",    bus_we,    1);
        checkOutput("wf_c1_bus_addr",  bus_addr,  16'h0200);
        checkOutput("wf_c1_bus_wdata", bus_wdata, 16'h1234);
        checkOutput("wf_c1_stall",     stall,     1);
        applyStimulus(1, 16'h0011, 0, 1, 16'h0200, 16'h1234, 0, 1, 16'h0000);
        checkOutput("wf_c2_mem_done", mem_done, 1);
        checkOutput("wf_c2_if_valid", if_valid, 0);
        checkOutput("wf_c2_stall",    stall,    1);
        applyStimulus(1, 16'h0011, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wf_c3_mem_done", mem_done, 0);
        checkOutput("wf_c3_bus_req",  bus_req,  0);
        checkOutput("wf_c3_stall",    stall,    1);
        applyStimulus(1, 16'h0011, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("wf_c4_bus_req",  bus_req,  1);
        checkOutput("wf_c4_bus_we",   bus_we,   0);
        checkOutput("wf_c4_bus_addr", bus_addr, 16'h0011);
        checkOutput("wf_c4_stall",    stall,    1);
        applyStimulus(1, 16'h0011, 0, 0, 0, 0, 0, 1, 16'h5555);
        checkOutput("wf_c5_if_valid", if_valid, 1);
        checkOutput("wf_c5_if_rdata", if_rdata, 16'h5555);
        checkOutput("wf_c5_stall",    stall,    0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load from 0x0300 with the grant withheld for 5 cycles
        applyStimulus(0, 0, 1, 0, 16'h0300, 0, 0, 0, 0);
        checkOutput("ld_c0_stall", stall, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 16'h0300, 0, 0, 1, 16'hDEAD);
            checkOutput("ld_hold_bus_req",  bus_req,  1);
            checkOutput("ld_hold_bus_addr", bus_addr, 16'h0300);
            checkOutput("ld_hold_mem_done", mem_done, 0);
        end
        applyStimulus(0, 0, 1, 0, 16'h0300, 0, 1, 0, 0);
        checkOutput("ld_gnt_bus_req", bus_req, 1);
        checkOutput("ld_gnt_bus_we",  bus_we,  0);
        applyStimulus(0, 0, 1, 0, 16'h0300, 0, 0, 1, 16'hBEEF);
        checkOutput("ld_done_mem_done",  mem_done,  1);
        checkOutput("ld_done_mem_rdata", mem_rdata, 16'hBEEF);
        checkOutput("ld_done_stall",     stall,     0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ld_after_mem_rdata", mem_rdata, 0);

        // Fetch 0x0020 redirected to 0x0040 while outstanding
        applyStimulus(1, 16'h0020, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 16'h0020, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("rd_c1_bus_addr", bus_addr, 16'h0020);
        applyStimulus(1, 16'h0040, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_c2_if_valid", if_valid, 0);
        applyStimulus(1, 16'h0040, 0, 0, 0, 0, 0, 1, 16'h1111);
        checkOutput("rd_c3_if_valid", if_valid, 0);
        checkOutput("rd_c3_stall",    stall,    1);
        applyStimulus(1, 16'h0040, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_c4_bus_req", bus_req, 0);
        applyStimulus(1, 16'h0040, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("rd_c5_bus_req",  bus_req,  1);
        checkOutput("rd_c5_bus_addr", bus_addr, 16'h0040);
        applyStimulus(1, 16'h0040, 0, 0, 0, 0, 0, 1, 16'h2222);
        checkOutput("rd_c6_if_valid", if_valid, 1);
        checkOutput("rd_c6_if_rdata", if_rdata, 16'h2222);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset asserted in D_WAIT, then a late response arrives
        applyStimulus(0, 0, 1, 0, 16'h0400, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 16'h0400, 0, 1, 0, 0);
        checkOutput("rs_c1_bus_addr", bus_addr, 16'h0400);
        applyStimulus(0, 0, 1, 0, 16'h0400, 0, 0, 0, 0);
        checkOutput("rs_c2_mem_done", mem_done, 0);
        #1;
        reset  = 1'b0;
        mem_rd = 1'b0;
        #1;
        checkOutput("rs_async_bus_addr", bus_addr, 0);
        checkOutput("rs_async_bus_req",  bus_req,  0);
        checkOutput("rs_async_stall",    stall,    0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 16'h9999);
        checkOutput("rs_late_mem_done",  mem_done,  0);
        checkOutput("rs_late_mem_rdata", mem_rdata, 0);
        checkOutput("rs_late_if_valid",  if_valid,  0);
        checkOutput("rs_late_bus_req",   bus_req,   0);
        checkOutput("rs_late_stall",     stall,     0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rs_idle_bus_req", bus_req, 0);

`ifdef CPU_BUS_FETCH_BUF_EN
        // Fill the buffer with 0x0010 -> 0xABCD
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0, 1, 16'hABCD);
        checkOutput("fb_fill_if_valid", if_valid, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Refetch hits: same-cycle data, no stall, no bus access
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fb_hit_if_valid", if_valid, 1);
        checkOutput("fb_hit_if_rdata", if_rdata, 16'hABCD);
        checkOutput("fb_hit_stall",    stall,    0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fb_hit_bus_req", bus_req, 0);
        // Store to 0x0010 invalidates the entry
        applyStimulus(0, 0, 0, 1, 16'h0010, 16'h7777, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 16'h0010, 16'h7777, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 16'h0010, 16'h7777, 0, 1, 0);
        checkOutput("fb_st_mem_done", mem_done, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Fetch 0x0010 now misses and goes to the bus
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fb_miss_if_valid", if_valid, 0);
        checkOutput("fb_miss_stall",    stall,    1);
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("fb_miss_bus_req",  bus_req,  1);
        checkOutput("fb_miss_bus_addr", bus_addr, 16'h0010);
        applyStimulus(1, 16'h0010, 0, 0, 0, 0, 0, 1, 16'h7777);
        checkOutput("fb_miss_if_rdata", if_rdata, 16'h7777);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
